fifo_wr_arbiter: RTL and testbench

- Shares the single write port of a FIFO among NREQ requesters.
- Uses round-robin arbitration with a bounded burst lock.
- Each requester uses a valid/ready handshake. The block drives the FIFO's w_data/wr_en and back-pressures on fifo_full.
- Sits directly in front of the FIFO write port, in the write clock domain.

---
 rtl/fifo_wr_arbiter_pkg.sv | 15 +
 rtl/fifo_wr_arbiter_if.sv | 30 +++
 rtl/fifo_wr_arbiter_rr.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 91 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO-side write/read arbiters.
// Zero-latency declarations only.
package fifo_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Index width for n items; never collapses to a zero-width vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the write-port arbiter.
// The arbiter uses the slave view; requesters/FIFO use the master view.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
);
  import fifo_ctrl_pkg::*;

  localparam int IW = idx_w(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      w_data;
  logic                  wr_en;
  logic                  fifo_full;
  logic                  grant_active;
  logic [IW-1:0]         grant_id;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, w_data, wr_en, grant_active, grant_id
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, w_data, wr_en, grant_active, grant_id
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr.sv
// Rotate-priority select: first set req bit at or after ptr, wrapping.
// Purely combinational; shared by write- and read-side arbiters.
module rr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic [idx_w(N)-1:0]   gnt_idx,
  output logic                  any_req
);

  localparam int IW = idx_w(N);

  // Scan from the farthest offset down so the nearest match wins last.
  always_comb begin
    int j;
    gnt_idx = '0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) gnt_idx = IW'(j);
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of one FIFO write port among NREQ requesters, bounded bursts.
// 1-cycle arbitration, one IDLE bubble per burst; fifo_full stalls the burst.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.slave   bus
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = idx_w(MAX_BURST + 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    r_rr_ptr;
  logic [CW-1:0]    r_beat_cnt;
  logic [IW-1:0]    w_gnt_idx;
  logic [IW-1:0]    w_ptr_after_owner;
  logic             w_any_req;
  logic             w_owner_vld;
  logic             w_beat;
  logic             w_last_beat;
  logic [NREQ-1:0]  w_req_ready;
  logic             w_wr_en;
  logic [WIDTH-1:0] w_wdata;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req     (bus.req_valid),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_gnt_idx),
    .any_req (w_any_req)
  );

  // Reset suppresses the in-flight beat so nothing is written on the reset cycle.
  assign w_owner_vld       = bus.req_valid[r_owner];
  assign w_beat            = (r_state == BURST) && w_owner_vld && !bus.fifo_full && !rst;
  assign w_last_beat       = w_beat && (r_beat_cnt == CW'(MAX_BURST - 1));
  assign w_ptr_after_owner = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_wr_en     = 1'b0;
    w_wdata     = '0;
    case (r_state)
      IDLE: begin
        if (w_any_req) w_state_nxt = BURST;
      end
      BURST: begin
        w_req_ready[r_owner] = !bus.fifo_full && !rst;
        w_wr_en              = w_beat;
        w_wdata              = bus.req_data[int'(r_owner)*WIDTH +: WIDTH];
        if (!w_owner_vld || w_last_beat) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (r_state == IDLE && w_any_req) begin
        r_owner    <= w_gnt_idx;
        r_beat_cnt <= '0;
      end
      if (w_beat) r_beat_cnt <= r_beat_cnt + 1'b1;
      if (r_state == BURST && w_state_nxt == IDLE) r_rr_ptr <= w_ptr_after_owner;
    end
  end

  assign bus.req_ready    = w_req_ready;
  assign bus.wr_en        = w_wr_en;
  assign bus.w_data       = w_wdata;
  assign bus.grant_active = (r_state == BURST);
  assign bus.grant_id     = r_owner;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized queues/backpressure
// checked against a transaction-level round-robin burst model.
module tb_fifo_wr_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  logic rst1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();
  fifo_wr_arbiter_if #(.WIDTH(W), .NREQ(N)) bus1 ();

  fifo_wr_arbiter #(.WIDTH(W), .NREQ(N), .MAX_BURST(MB)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  fifo_wr_arbiter #(.WIDTH(W), .NREQ(N), .MAX_BURST(1)) dut1 (
    .clk (clk), .rst (rst1), .bus (bus1)
  );

  int n_chk;
  int n_fail;

  logic [W-1:0] src [N][$];
  logic [W-1:0] m   [N][$];

  bit           lg_ga  [$];
  bit           lg_wr  [$];
  int           lg_gid [$];
  int           lg_cnt [$];
  logic [N-1:0] lg_rdy [$];
  logic [W-1:0] lg_dat [$];
  logic [W-1:0] wrote  [$];

  int           exp_own   [$];
  int           exp_len   [$];
  logic [W-1:0] exp_words [$];
  int           exp_cycles;

  task automatic drive();
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    v = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (src[i].size() > 0) begin
        v[i]         = 1'b1;
        d[i*W +: W]  = src[i][0];
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
  endtask

  task automatic clear_logs();
    lg_ga.delete(); lg_wr.delete(); lg_gid.delete(); lg_cnt.delete();
    lg_rdy.delete(); lg_dat.delete(); wrote.delete();
  endtask

  // One clock: sample at negedge, consume accepted words after the posedge.
  task automatic cycle();
    logic [N-1:0] rdy;
    logic [N-1:0] vld;
    @(negedge clk);
    rdy = bus.req_ready;
    vld = bus.req_valid;
    lg_ga.push_back(bus.grant_active);
    lg_wr.push_back(bus.wr_en);
    lg_gid.push_back(int'(bus.grant_id));
    lg_cnt.push_back(int'(dut.r_beat_cnt));
    lg_rdy.push_back(rdy);
    lg_dat.push_back(bus.w_data);
    if (bus.wr_en) wrote.push_back(bus.w_data);
    n_chk++;
    if (bus.wr_en && (bus.fifo_full || !bus.grant_active)) begin
      n_fail++;
      $display("FAIL wr_en_legal: wr_en=1 with fifo_full=%0d grant_active=%0d, required no write", bus.fifo_full, bus.grant_active);
    end
    n_chk++;
    if ($countones(rdy) > 1) begin
      n_fail++;
      $display("FAIL ready_onehot: req_ready=%b, required at most one bit", rdy);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (rdy[i] && vld[i]) void'(src[i].pop_front());
    drive();
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < N; i++) src[i].delete();
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
  endtask

  task automatic load(input int id, input int n);
    for (int k = 0; k < n; k++)
      src[id].push_back({8'(id), 8'(k), 16'($urandom)});
  endtask

  // Burst-level model: rr pick among non-empty queues, take up to MB words each.
  task automatic run_model();
    int ptr;
    int o;
    int k;
    bit any;
    for (int i = 0; i < N; i++) m[i] = src[i];
    exp_own.delete(); exp_len.delete(); exp_words.delete();
    exp_cycles = 0;
    ptr = 0;
    any = 1'b1;
    while (any) begin
      o = -1;
      for (int j = 0; j < N; j++)
        if (o < 0 && m[(ptr + j) % N].size() > 0) o = (ptr + j) % N;
      if (o < 0) begin
        any = 1'b0;
      end else begin
        k = (m[o].size() < MB) ? m[o].size() : MB;
        for (int b = 0; b < k; b++) exp_words.push_back(m[o].pop_front());
        exp_own.push_back(o);
        exp_len.push_back(k);
        exp_cycles += (k == MB) ? MB + 1 : k + 2;
        ptr = (o + 1) % N;
      end
    end
  endtask

  task automatic run_until_drained(input bit rnd_full, input int bound, input string nm);
    int  c;
    bit  done;
    bit  empty;
    c    = 0;
    done = 1'b0;
    while (!done && c < bound) begin
      if (rnd_full) bus.fifo_full = ($urandom_range(0, 3) == 0);
      cycle();
      c++;
      empty = 1'b1;
      for (int i = 0; i < N; i++) if (src[i].size() > 0) empty = 1'b0;
      if (empty && !lg_ga[lg_ga.size()-1]) done = 1'b1;
    end
    bus.fifo_full = 1'b0;
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_timeout: not drained after %0d cycles, required drain", nm, bound);
    end
  endtask

  task automatic check_bursts(input string nm);
    int o_own [$];
    int o_len [$];
    for (int c = 0; c < lg_ga.size(); c++) begin
      if (lg_ga[c] && (c == 0 || !lg_ga[c-1])) begin
        o_own.push_back(lg_gid[c]);
        o_len.push_back(0);
      end
      if (lg_wr[c] && o_len.size() > 0) o_len[o_len.size()-1] = o_len[o_len.size()-1] + 1;
    end
    n_chk++;
    if (o_own.size() != exp_own.size()) begin
      n_fail++;
      $display("FAIL %s_nbursts: got %0d expected %0d", nm, o_own.size(), exp_own.size());
    end else begin
      for (int b = 0; b < o_own.size(); b++) begin
        n_chk++;
        if (o_own[b] !== exp_own[b] || o_len[b] !== exp_len[b]) begin
          n_fail++;
          $display("FAIL %s_burst%0d: got owner %0d beats %0d expected owner %0d beats %0d",
                   nm, b, o_own[b], o_len[b], exp_own[b], exp_len[b]);
        end
      end
    end
    n_chk++;
    if (wrote.size() != exp_words.size()) begin
      n_fail++;
      $display("FAIL %s_nwords: got %0d expected %0d", nm, wrote.size(), exp_words.size());
    end else begin
      for (int i = 0; i < wrote.size(); i++) begin
        n_chk++;
        if (wrote[i] !== exp_words[i]) begin
          n_fail++;
          $display("FAIL %s_word%0d: got %h expected %h", nm, i, wrote[i], exp_words[i]);
        end
      end
    end
  endtask

  task automatic check_span(input string nm);
    int last;
    last = -1;
    for (int c = 0; c < lg_ga.size(); c++) if (lg_ga[c]) last = c;
    n_chk++;
    if (last + 1 != exp_cycles) begin
      n_fail++;
      $display("FAIL %s_cycles: got %0d busy cycles expected %0d", nm, last + 1, exp_cycles);
    end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.fifo_full  = 1'b0;
    bus.req_valid  = '1;
    bus.req_data   = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (bus.grant_active !== 1'b0 || bus.grant_id !== '0 || bus.wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got ga=%b gid=%0d wr=%b expected 0 0 0", bus.grant_active, bus.grant_id, bus.wr_en);
    end
    n_chk++;
    if (bus.req_ready !== '0 || bus.w_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got ready=%b w_data=%h expected 0 0", bus.req_ready, bus.w_data);
    end
  endtask

  task automatic test_single_stream();
    do_reset();
    load(2, 10);
    run_model();
    drive();
    run_until_drained(1'b0, 100, "single");
    check_bursts("single");
    check_span("single");
  endtask

  task automatic test_all_valid();
    do_reset();
    for (int i = 0; i < N; i++) load(i, 8);
    run_model();
    drive();
    run_until_drained(1'b0, 200, "allv");
    check_bursts("allv");
    check_span("allv");
  endtask

  task automatic test_full_stall();
    do_reset();
    load(0, 4);
    run_model();
    drive();
    for (int c = 0; c < 13; c++) begin
      bus.fifo_full = (c >= 3 && c <= 7);
      cycle();
    end
    bus.fifo_full = 1'b0;
    for (int c = 3; c <= 7; c++) begin
      n_chk++;
      if (lg_wr[c] !== 1'b0 || lg_rdy[c] !== '0 || lg_cnt[c] != 2 || lg_ga[c] !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_c%0d: got wr=%b ready=%b cnt=%0d ga=%b expected 0 0 2 1",
                 c, lg_wr[c], lg_rdy[c], lg_cnt[c], lg_ga[c]);
      end
    end
    n_chk++;
    if (lg_wr[8] !== 1'b1 || lg_wr[9] !== 1'b1 || lg_ga[10] !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_resume: got wr8=%b wr9=%b ga10=%b expected 1 1 0", lg_wr[8], lg_wr[9], lg_ga[10]);
    end
    check_bursts("stall");
  endtask

  task automatic test_owner_drop();
    do_reset();
    load(1, 2);
    load(3, 3);
    run_model();
    drive();
    run_until_drained(1'b0, 100, "drop");
    n_chk++;
    if (lg_ga[3] !== 1'b1 || lg_wr[3] !== 1'b0 || lg_ga[4] !== 1'b0 || lg_ga[5] !== 1'b1 || lg_gid[5] != 3) begin
      n_fail++;
      $display("FAIL drop_handover: got ga3=%b wr3=%b ga4=%b ga5=%b gid5=%0d expected 1 0 0 1 3",
               lg_ga[3], lg_wr[3], lg_ga[4], lg_ga[5], lg_gid[5]);
    end
    check_bursts("drop");
    check_span("drop");
  endtask

  task automatic test_reset_mid_burst();
    logic [W-1:0] w3;
    do_reset();
    load(2, 6);
    load(3, 2);
    w3 = src[2][2];
    drive();
    for (int c = 0; c < 8; c++) begin
      rst = (c == 3);
      cycle();
    end
    rst = 1'b0;
    n_chk++;
    if (lg_wr[1] !== 1'b1 || lg_wr[2] !== 1'b1 || lg_gid[1] != 2) begin
      n_fail++;
      $display("FAIL rstmid_pre: got wr1=%b wr2=%b gid1=%0d expected 1 1 2", lg_wr[1], lg_wr[2], lg_gid[1]);
    end
    n_chk++;
    if (lg_wr[3] !== 1'b0 || lg_rdy[3] !== '0) begin
      n_fail++;
      $display("FAIL rstmid_beat3: got wr=%b ready=%b expected 0 0", lg_wr[3], lg_rdy[3]);
    end
    n_chk++;
    if (lg_ga[4] !== 1'b0 || lg_gid[4] != 0 || lg_wr[4] !== 1'b0 || lg_rdy[4] !== '0 || lg_dat[4] !== '0) begin
      n_fail++;
      $display("FAIL rstmid_after: got ga=%b gid=%0d wr=%b ready=%b data=%h expected all 0",
               lg_ga[4], lg_gid[4], lg_wr[4], lg_rdy[4], lg_dat[4]);
    end
    n_chk++;
    if (lg_ga[5] !== 1'b1 || lg_gid[5] != 2 || lg_wr[5] !== 1'b1 || lg_dat[5] !== w3) begin
      n_fail++;
      $display("FAIL rstmid_regrant: got ga=%b gid=%0d wr=%b data=%h expected 1 2 1 %h",
               lg_ga[5], lg_gid[5], lg_wr[5], lg_dat[5], w3);
    end
  endtask

  task automatic test_max_burst1();
    int nwr;
    int expg;
    rst1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b0;
    nwr  = 0;
    expg = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n_chk++;
      if (bus1.wr_en !== 1'(c % 2)) begin
        n_fail++;
        $display("FAIL mb1_wr_c%0d: got %b expected %0d", c, bus1.wr_en, c % 2);
      end
      if (bus1.wr_en) begin
        nwr++;
        n_chk++;
        if (int'(bus1.grant_id) != expg) begin
          n_fail++;
          $display("FAIL mb1_gid_c%0d: got %0d expected %0d", c, bus1.grant_id, expg);
        end
        expg = 1 - expg;
      end
    end
    n_chk++;
    if (nwr != 20) begin
      n_fail++;
      $display("FAIL mb1_duty: got %0d writes in 40 cycles expected 20", nwr);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int i = 0; i < N; i++) load(i, $urandom_range(0, 9));
      run_model();
      drive();
      run_until_drained(1'b1, 600, "rand");
      check_bursts("rand");
    end
  endtask

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    rst            = 1'b1;
    rst1           = 1'b1;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.fifo_full  = 1'b0;
    bus1.req_valid = 4'b0011;
    bus1.req_data  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    bus1.fifo_full = 1'b0;
    test_reset();
    test_single_stream();
    test_all_valid();
    test_full_stall();
    test_owner_drop();
    test_reset_mid_burst();
    test_max_burst1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
